// File: rtl/pred_ctx_sequencer.sv
// Per-PE context sequencer: plays predicate-control words from a small context memory into pred_reg1.
// Optional multi-pass looping over the context range is enabled with `define PRED_SEQ_LOOP_EN.
module pred_ctx_sequencer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int NOP_SLOT = 63
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [46:0]   cfg_data,
    input  logic          start,
    input  logic          stall,
    input  logic [AW-1:0] last_idx,
    input  logic [7:0]    iter_cnt,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [AW-1:0] ctx_pc,
    output logic [8:0]    control_in_p,
    output logic [8:0]    control_out_p,
    output logic [5:0]    control_put_in_p,
    output logic [5:0]    control_put_out_p,
    output logic [5:0]    control_pred,
    output logic [5:0]    control_send_p,
    output logic [3:0]    control_pe2fu_p,
    output logic          write_back_p
);

    // Idle word steers the unconditional per-cycle put into a scratch register
    localparam logic [46:0] NOP_WORD = {9'd0, 9'd0, 6'(NOP_SLOT), 6'(NOP_SLOT),
                                        6'd0, 6'd0, 4'd0, 1'b0};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [46:0]   mem [DEPTH];
    logic [46:0]   word_q, word_n;
    logic [AW-1:0] pc_n, pc_inc, last_q, last_n;
    logic          busy_n, done_n, err_n, mem_we, another_pass;

`ifdef PRED_SEQ_LOOP_EN
    logic [7:0] iter_q, iter_n;
    assign another_pass = (iter_q > 8'd1);
`else
    logic unused_iter;
    assign unused_iter  = ^iter_cnt;
    assign another_pass = 1'b0;
`endif

    assign pc_inc = ctx_pc + 1'b1;

    always_comb begin
        state_n = state;
        word_n  = word_q;
        pc_n    = ctx_pc;
        last_n  = last_q;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        mem_we  = 1'b0;
`ifdef PRED_SEQ_LOOP_EN
        iter_n  = iter_q;
`endif
        case (state)
            IDLE: begin
                word_n = NOP_WORD;
                busy_n = 1'b0;
                mem_we = cfg_we;
                if (start) begin
                    last_n  = last_idx;
`ifdef PRED_SEQ_LOOP_EN
                    iter_n  = (iter_cnt == 8'd0) ? 8'd1 : iter_cnt;
`endif
                    pc_n    = '0;
                    // Same-cycle config write to slot 0 must be visible in the first context
                    word_n  = (cfg_we && cfg_addr == '0) ? cfg_data : mem[0];
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                err_n = cfg_we;
                if (!stall) begin
                    if (ctx_pc != last_q) begin
                        pc_n   = pc_inc;
                        word_n = mem[pc_inc];
                    end else if (another_pass) begin
`ifdef PRED_SEQ_LOOP_EN
                        iter_n = iter_q - 8'd1;
`endif
                        pc_n   = '0;
                        word_n = mem[0];
                    end else begin
                        word_n  = NOP_WORD;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                err_n   = cfg_we;
                word_n  = NOP_WORD;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                word_n  = NOP_WORD;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            word_q  <= NOP_WORD;
            ctx_pc  <= '0;
            last_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
`ifdef PRED_SEQ_LOOP_EN
            iter_q  <= 8'd0;
`endif
        end else begin
            state   <= state_n;
            word_q  <= word_n;
            ctx_pc  <= pc_n;
            last_q  <= last_n;
            busy    <= busy_n;
            done    <= done_n;
            cfg_err <= err_n;
`ifdef PRED_SEQ_LOOP_EN
            iter_q  <= iter_n;
`endif
        end
    end

    // Context memory is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    assign control_in_p      = word_q[46:38];
    assign control_out_p     = word_q[37:29];
    assign control_put_in_p  = word_q[28:23];
    assign control_put_out_p = word_q[22:17];
    assign control_pred      = word_q[16:11];
    assign control_send_p    = word_q[10:5];
    assign control_pe2fu_p   = word_q[4:1];
    assign write_back_p      = word_q[0];

endmodule
